// File: rtl/mem_access_unit_if.sv
// Request/response and word-addressed memory port bundle for mem_access_unit.
// slave is the unit's view; master is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int MEM_DEPTH = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_error;
  logic [1:0]           memory_write_width;
  logic [MEM_DEPTH-1:0] memory_write_address;
  logic [31:0]          memory_write_data;
  logic                 memory_write_enable;
  logic [MEM_DEPTH-1:0] memory_read_address;
  logic [31:0]          memory_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, memory_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           memory_write_width, memory_write_address, memory_write_data,
           memory_write_enable, memory_read_address
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, memory_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           memory_write_width, memory_write_address, memory_write_data,
           memory_write_enable, memory_read_address
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, with sign/zero-extended loads,
// native narrow stores at offset 0 and read-modify-write for other sub-word stores.
module mem_access_unit #(
  parameter int MEM_DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_READ,
    S_RMW_WRITE,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [31:0]          r_wdata;
  logic [1:0]           r_off;
  logic [MEM_DEPTH-1:0] r_waddr;
  logic [31:0]          r_merged;
  logic [31:0]          r_rdata;
  logic                 r_error;

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_misaligned;
  logic                 w_error;
  logic [1:0]           w_req_off;
  logic [31:0]          w_shifted;
  logic [31:0]          w_load_data;
  logic [31:0]          w_merged;
  logic                 w_req_ready;
  logic                 w_rsp_valid;
  logic                 w_wr_en;
  logic [1:0]           w_wr_width;
  logic [31:0]          w_wr_data;

  assign w_req_off = bus.req_addr[1:0];
  assign w_accept  = bus.req_valid && (r_state == S_IDLE);

  // funct3[1:0] gives the access size for every legal encoding: 0 byte, 1 half, 2 word.
  always_comb begin
    w_illegal    = bus.req_write ? (bus.req_funct3 > 3'd2)
                                 : (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6);
    w_misaligned = ((bus.req_funct3[1:0] == 2'd1) && w_req_off[0]) ||
                   ((bus.req_funct3[1:0] == 2'd2) && (w_req_off != 2'd0));
    w_error      = w_illegal || w_misaligned;
  end

  always_comb begin
    w_shifted = bus.memory_read_data >> {r_off, 3'b000};
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd4:    w_load_data = {24'd0, w_shifted[7:0]};
      3'd5:    w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = bus.memory_read_data;
    endcase
  end

  // RMW only ever sees SB at offsets 1..3 or SH at offset 2.
  always_comb begin
    w_merged = bus.memory_read_data;
    if (r_funct3[1:0] == 2'd0) begin
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[31:16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignment so every process samples the pre-edge value.
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_width  = 2'd0;
    w_wr_data   = 32'd0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_error)                 w_next = S_RESP;
          else if (!bus.req_write)     w_next = S_LOAD;
          else if (w_req_off == 2'd0)  w_next = S_WRITE;
          else                         w_next = S_RMW_READ;
        end
      end
      S_LOAD:     w_next = S_RESP;
      S_WRITE: begin
        w_wr_en    = 1'b1;
        w_wr_width = r_funct3[1:0] + 2'd1;
        w_wr_data  = r_wdata;
        w_next     = S_RESP;
      end
      S_RMW_READ: w_next = S_RMW_WRITE;
      S_RMW_WRITE: begin
        w_wr_en    = 1'b1;
        w_wr_width = 2'd3;
        w_wr_data  = r_merged;
        w_next     = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, since several of them drive outputs that must read 0 after reset.
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_wdata  <= 32'd0;
      r_off    <= 2'd0;
      r_waddr  <= '0;
      r_merged <= 32'd0;
      r_rdata  <= 32'd0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_funct3 <= bus.req_funct3;
        r_wdata  <= bus.req_wdata;
        r_off    <= w_req_off;
        r_waddr  <= bus.req_addr[MEM_DEPTH+1:2];
        r_rdata  <= 32'd0;
        r_error  <= w_error;
      end
      if (r_state == S_LOAD)     r_rdata  <= w_load_data;
      if (r_state == S_RMW_READ) r_merged <= w_merged;
    end
  end

  assign bus.req_ready            = w_req_ready;
  assign bus.rsp_valid            = w_rsp_valid;
  assign bus.rsp_rdata            = r_rdata;
  assign bus.rsp_error            = w_rsp_valid && r_error;
  assign bus.memory_write_enable  = w_wr_en;
  assign bus.memory_write_width   = w_wr_width;
  assign bus.memory_write_data    = w_wr_data;
  assign bus.memory_write_address = (r_state != S_IDLE) ? r_waddr : '0;
  assign bus.memory_read_address  = (r_state != S_IDLE) ? r_waddr : '0;

  logic w_unused;
  assign w_unused = r_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores
// against a byte-array reference memory.
module tb_mem_access_unit;
  localparam int MEM_DEPTH = 10;
  localparam int NWORDS    = 1 << MEM_DEPTH;
  localparam int NBYTES    = NWORDS * 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_access_unit_if #(.MEM_DEPTH(MEM_DEPTH)) bus();
  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the port; preload requests share the same write process.
  bit [31:0]            mem [NWORDS];
  bit                   pre_en;
  bit [MEM_DEPTH-1:0]   pre_idx;
  bit [31:0]            pre_val;

  assign bus.memory_read_data = mem[bus.memory_read_address];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.memory_write_enable) begin
      case (bus.memory_write_width)
        2'd1:    mem[bus.memory_write_address][7:0]  <= bus.memory_write_data[7:0];
        2'd2:    mem[bus.memory_write_address][15:0] <= bus.memory_write_data[15:0];
        2'd3:    mem[bus.memory_write_address]       <= bus.memory_write_data;
        default: ;
      endcase
    end
  end

  // Reference memory: a flat byte array addressed modulo its size.
  bit [7:0] ref_b [NBYTES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input bit [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx[MEM_DEPTH-1:0];
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[idx*4 + i] = val[8*i +: 8];
  endtask

  task automatic model_access(input bit w, input bit [2:0] f3, input bit [31:0] addr,
                              input bit [31:0] wd, output bit err, output bit [31:0] rdata,
                              output int lat, output bit [1:0] wwidth, output bit [31:0] wdata);
    int  size;
    bit  sgn;
    int  base;
    int  wbase;
    bit [31:0] v;
    size = 0; sgn = 0; rdata = 0; wwidth = 0; wdata = 0;
    if (w) begin
      if (f3 == 0) size = 1; else if (f3 == 1) size = 2; else if (f3 == 2) size = 4;
    end else begin
      case (f3)
        0: begin size = 1; sgn = 1; end
        1: begin size = 2; sgn = 1; end
        2: size = 4;
        4: size = 1;
        5: size = 2;
        default: size = 0;
      endcase
    end
    base = int'(addr % NBYTES);
    err  = (size == 0) || (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 0);
    if (err) begin
      lat = 1;
    end else if (!w) begin
      lat = 2;
      v = 0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_b[base + i]) << (8 * i));
      if (sgn && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      rdata = v;
    end else begin
      for (int i = 0; i < size; i++) ref_b[base + i] = wd[8*i +: 8];
      if (addr[1:0] == 0) begin
        lat    = 2;
        wwidth = (size == 4) ? 2'd3 : 2'(size);
        wdata  = wd;
      end else begin
        lat    = 3;
        wwidth = 2'd3;
        wbase  = base - int'(addr[1:0]);
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = ref_b[wbase + i];
      end
    end
  endtask

  task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, output logic [31:0] got_rdata);
    bit        exp_err;
    bit [31:0] exp_rd;
    int        exp_lat;
    bit [1:0]  exp_width;
    bit [31:0] exp_wdata;
    int        lat;
    int        wr_cnt;
    int        waited;
    logic      got_err;
    logic [1:0]  wr_width;
    logic [31:0] wr_data;
    bit        idle_dirty;
    bit        ready_leak;
    lat = 0; wr_cnt = 0; waited = 0; got_err = 1'bx; got_rdata = 'x;
    wr_width = 0; wr_data = 0; idle_dirty = 0; ready_leak = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", 32'(bus.req_ready), 32'd1);
    model_access(w, f3, addr, wd, exp_err, exp_rd, exp_lat, exp_width, exp_wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.memory_write_enable === 1'b1) begin
        wr_cnt++;
        wr_width = bus.memory_write_width;
        wr_data  = bus.memory_write_data;
      end else if (bus.memory_write_width !== 2'd0 || bus.memory_write_data !== 32'd0) begin
        idle_dirty = 1'b1;
      end
      if (bus.req_ready !== 1'b0) ready_leak = 1'b1;
      if (bus.rsp_valid === 1'b1) begin
        lat       = c;
        got_err   = bus.rsp_error;
        got_rdata = bus.rsp_rdata;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_error", 32'(got_err), 32'(exp_err));
    check("rsp_rdata", got_rdata, exp_rd);
    check("write_count", 32'(wr_cnt), (w && !exp_err) ? 32'd1 : 32'd0);
    check("idle_write_lines", 32'(idle_dirty), 32'd0);
    check("ready_while_busy", 32'(ready_leak), 32'd0);
    if (w && !exp_err) begin
      check("write_width", 32'(wr_width), 32'(exp_width));
      check("write_data", wr_data, exp_wdata);
    end
  endtask

  logic [31:0] r;
  int          strobes;
  int          mism;

  initial begin
    n_checks = 0;
    n_errors = 0;
    pre_en = 0; pre_idx = 0; pre_val = 0;
    rst_n = 1'b0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_we", 32'(bus.memory_write_enable), 32'd0);
    check("reset_width", 32'(bus.memory_write_width), 32'd0);
    check("reset_wdata", bus.memory_write_data, 32'd0);
    check("reset_waddr", 32'(bus.memory_write_address), 32'd0);
    check("reset_raddr", 32'(bus.memory_read_address), 32'd0);
    rst_n = 1'b1;

    set_word(4, 32'h8899_AABB);
    do_req(0, 3'd2, 32'h10, 0, r);          check("lw_word4", r, 32'h8899_AABB);
    do_req(0, 3'd0, 32'h13, 0, r);          check("lb_sign", r, 32'hFFFF_FF88);
    do_req(0, 3'd4, 32'h13, 0, r);          check("lbu_zero", r, 32'h0000_0088);
    do_req(0, 3'd5, 32'h12, 0, r);          check("lhu_upper", r, 32'h0000_8899);
    do_req(0, 3'd2, 32'hFFFF_F010, 0, r);   check("lw_wrap", r, 32'h8899_AABB);
    set_word(0, 32'h1122_3344);
    do_req(1, 3'd0, 32'h00, 32'hA5A5_A55A, r);
    do_req(0, 3'd2, 32'h00, 0, r);          check("sb_narrow_result", r, 32'h1122_335A);
    set_word(8, 32'h1122_3344);
    do_req(1, 3'd1, 32'h22, 32'h0000_BEEF, r);
    do_req(0, 3'd2, 32'h20, 0, r);          check("sh_rmw_result", r, 32'hBEEF_3344);
    do_req(0, 3'd2, 32'h02, 0, r);
    do_req(1, 3'd1, 32'h05, 32'h1234_5678, r);
    do_req(0, 3'd3, 32'h10, 0, r);
    do_req(1, 3'd5, 32'h10, 32'hDEAD_BEEF, r);
    do_req(0, 3'd2, 32'h10, 0, r);          check("illegal_store_no_effect", r, 32'h8899_AABB);

    // Reset during RMW_READ of SB at 0x41: no write, outputs cleared, word intact.
    set_word(16, 32'hCAFE_F00D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h41; bus.req_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_read_addr", 32'(bus.memory_read_address), 32'd16);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_we", 32'(bus.memory_write_enable), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_raddr", 32'(bus.memory_read_address), 32'd0);
    check("abort_waddr", 32'(bus.memory_write_address), 32'd0);
    check("abort_width", 32'(bus.memory_write_width), 32'd0);
    check("abort_wdata", bus.memory_write_data, 32'd0);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.memory_write_enable !== 1'b0) strobes++;
    end
    check("abort_no_strobe", 32'(strobes), 32'd0);
    rst_n = 1'b1;
    do_req(0, 3'd2, 32'h40, 0, r);          check("abort_word_intact", r, 32'hCAFE_F00D);

    for (int t = 0; t < 300; t++) begin
      bit        w;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] wd;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      a  = 32'($urandom_range(0, 95));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hFFFF_F000);
      wd = $urandom();
      do_req(w, f3, a, wd, r);
    end

    repeat (2) @(negedge clk);
    mism = 0;
    for (int i = 0; i < NWORDS; i++) begin
      if (mem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) mism++;
    end
    check("memory_image", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
